cmplx_twiddle_mult: RTL and testbench
=====================================

// Module: cmplx_twiddle_mult
// PURPOSE
//  Pipelined signed complex multiplier: y = a * w, where a is FFT butterfly data and w is a twiddle.
//  Parametrised successor to the fixed 8x9 registered real multiplier; adds complex math, scaling,
//  a valid/ready handshake with back-pressure, and a sideband tag carried aligned with the data.
//  Sits in each FFT stage between the butterfly and the next stage's input buffer.
// PARAMETERS
//  A_W       8  data component width (signed, re and im each)
//  B_W       9  twiddle component width (signed; 1.0 == 2**FRAC_BITS)
//  FRAC_BITS 7  twiddle fraction bits; products are shifted right by this amount
//  OUT_W     9  output component width (signed)
//  TAG_W     4  sideband tag width (sample index / channel); passed through unchanged
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat present
//  in_ready   out  1      block accepts the beat this cycle
//  a_re,a_im  in   A_W    data, signed
//  w_re,w_im  in   B_W    twiddle, signed
//  in_tag     in   TAG_W  sideband
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts the result
//  y_re,y_im  out  OUT_W  result, signed
//  out_tag    out  TAG_W  tag of the result beat
//  ovf        out  1      beat saturated (ROUND_SAT_EN only, else constant 0)
// BEHAVIOUR
//  - Reset: every valid bit, y_re, y_im, out_tag and ovf are 0. In-flight beats are discarded, and
//    this also applies to a reset asserted mid-stream.
//  - Pipeline has 3 stages. S1 registers the inputs. S2 registers the four full products
//    (A_W+B_W bits): ar*wr, ai*wi, ar*wi, ai*wr. S3 registers the scaled results:
//    re = ar*wr - ai*wi and im = ar*wi + ai*wr, computed at A_W+B_W+1 bits, then scaled to OUT_W.
//  - Latency is 3 clk from the accepting edge to out_valid, with no stalls.
//    Throughput is 1 beat/clk while out_ready = 1.
//  - Handshake: a beat transfers when valid && ready. stall = out_valid && !out_ready.
//    in_ready = !stall, computed combinationally from out_ready.
//    While stall is high, all stages hold (global enable). Bubbles are not compressed.
//  - Outputs stay stable while out_valid && !out_ready. No beat is lost, duplicated or reordered.
//  - The tag travels with its beat through all 3 stages.
// CONFIGURATION
//  - ROUND_SAT_EN defined:
//    - Round half-up: add 2**(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
//    - Saturate to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
//    - ovf = 1 with the beat if either component clipped.
//  - ROUND_SAT_EN undefined:
//    - Truncate: arithmetic shift right (floor).
//    - Wrap: keep the low OUT_W bits.
//    - ovf is tied 0.
// STRUCTURE
//  - Shared package fft_pkg holds the twiddle Q-format constants (TW_FRAC = 7, TW_ONE = 128)
//    and the default data/output widths.
//  - One sub-module, fft_scale, implements the shift/round/saturate of a single component.
//    It is instantiated twice in S3 and is the only code affected by ROUND_SAT_EN.
// TESTING
//  1. Identity: a = (100,-50), w = (128,0), out_ready = 1 -> y = (100,-50) exactly 3 clk later, ovf = 0.
//  2. Multiply by -j: a = (100,-50), w = (0,-128) -> y = (-50,-100); tag 0xA in gives out_tag 0xA.
//  3. Scaling: a = (1,0), w = (64,0) -> y_re = 1 with the macro, 0 without.
//     a = (-1,0), w = (64,0) -> y_re = 0 with the macro, -1 without.
//  4. Overflow: a = (127,127), w = (255,255) -> y = (0,255), ovf = 1 with the macro;
//     without it y = (0,-6), ovf = 0.
//  5. Back-pressure: stream 6 beats with tags 0..5, out_ready = 0 for 5 clk mid-stream ->
//     in_ready drops; outputs hold stable; all 6 beats emerge in order, none lost or duplicated.
//  6. Reset mid-stream: assert rst with 3 beats in flight -> out_valid = 0 immediately;
//     after release, the first new beat appears 3 clk after acceptance and no stale data emerges.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants for the FFT datapath.
//   TW_FRAC / TW_ONE : twiddle Q-format (1.0 == TW_ONE == 2**TW_FRAC)
//   DATA_W           : default butterfly data component width
//   TW_W             : default twiddle component width
//   RES_W            : default multiplier output component width
//   TAG_W_DEF        : default sideband tag width
// -----------------------------------------------------------------------------
package fft_pkg;
    localparam int TW_FRAC   = 7;
    localparam int TW_ONE    = 1 << TW_FRAC;
    localparam int DATA_W    = 8;
    localparam int TW_W      = 9;
    localparam int RES_W     = 9;
    localparam int TAG_W_DEF = 4;
endpackage

// File: rtl/fft_scale.sv
// -----------------------------------------------------------------------------
// fft_scale
// Scales one signed product sum down by FRAC fraction bits to OUT_W bits.
// Build option (macro ROUND_SAT_EN):
//   defined   : round half-up, saturate to the OUT_W signed range, ovf flags a clip
//   undefined : truncate (floor), wrap to the low OUT_W bits, ovf tied 0
// Ports:
//   x   in  IN_W   signed full-precision value
//   y   out OUT_W  signed scaled value
//   ovf out 1      value was clipped (always 0 without ROUND_SAT_EN)
// -----------------------------------------------------------------------------
module fft_scale #(
    parameter int IN_W  = 18,
    parameter int FRAC  = 7,
    parameter int OUT_W = 9
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf
);

`ifdef ROUND_SAT_EN
    // One guard bit keeps the rounding add from overflowing.
    localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1 << (FRAC-1));
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = -MAX_V - (IN_W+1)'(1);

    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] shifted;

    assign rounded = (IN_W+1)'(x) + HALF;
    assign shifted = rounded >>> FRAC;

    always_comb begin
        // NOTE: defaults come first so every path assigns y and ovf; no latch is inferred.
        y   = OUT_W'(shifted);
        ovf = 1'b0;
        if (shifted > MAX_V) begin
            y   = OUT_W'(MAX_V);
            ovf = 1'b1;
        end else if (shifted < MIN_V) begin
            y   = OUT_W'(MIN_V);
            ovf = 1'b1;
        end
    end
`else
    // Arithmetic shift floors toward -inf; the cast keeps the low OUT_W bits (wrap).
    assign y   = OUT_W'(x >>> FRAC);
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/cmplx_twiddle_mult.sv
// -----------------------------------------------------------------------------
// cmplx_twiddle_mult
// Pipelined signed complex multiplier y = a * w (FFT data times twiddle) with a
// valid/ready handshake, global-enable back-pressure and an aligned sideband tag.
// Stages: S1 input regs -> S2 four partial products -> S3 scaled result regs.
// out_valid rises on the third rising edge, counting the edge that accepts the beat.
// Build option: ROUND_SAT_EN selects round/saturate scaling (see fft_scale).
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready   input handshake; in_ready = !(out_valid && !out_ready)
//   a_re, a_im          data, signed A_W
//   w_re, w_im          twiddle, signed B_W (1.0 == 2**FRAC_BITS)
//   in_tag              sideband, carried with the beat
//   out_valid/out_ready output handshake
//   y_re, y_im          result, signed OUT_W
//   out_tag             tag of the result beat
//   ovf                 result beat was saturated (0 without ROUND_SAT_EN)
// -----------------------------------------------------------------------------
module cmplx_twiddle_mult
    import fft_pkg::*;
#(
    parameter int A_W       = DATA_W,
    parameter int B_W       = TW_W,
    parameter int FRAC_BITS = TW_FRAC,
    parameter int OUT_W     = RES_W,
    parameter int TAG_W     = TAG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a_re,
    input  logic signed [A_W-1:0]   a_im,
    input  logic signed [B_W-1:0]   w_re,
    input  logic signed [B_W-1:0]   w_im,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y_re,
    output logic signed [OUT_W-1:0] y_im,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    ovf
);

    localparam int P_W = A_W + B_W;   // full product width
    localparam int S_W = P_W + 1;     // sum/difference width

    // Whole pipeline advances together; bubbles are held, not squeezed out.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // ---------------- S1: input registers ----------------
    logic                  s1_valid;
    logic signed [A_W-1:0] s1_ar, s1_ai;
    logic signed [B_W-1:0] s1_wr, s1_wi;
    logic [TAG_W-1:0]      s1_tag;

    // NOTE: non-blocking assignments in clocked blocks so each stage samples pre-edge values.
    // NOTE: data registers are reset along with the valids so nothing stale or X survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
            s1_tag   <= '0;
        end else if (en) begin
            // in_ready == en, so a present beat is accepted exactly here.
            s1_valid <= in_valid;
            s1_ar    <= a_re;
            s1_ai    <= a_im;
            s1_wr    <= w_re;
            s1_wi    <= w_im;
            s1_tag   <= in_tag;
        end
    end

    // ---------------- S2: partial products ----------------
    logic                  s2_valid;
    logic signed [P_W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic [TAG_W-1:0]      s2_tag;

    // Operands are sign-extended to the full product width before multiplying.
    function automatic logic signed [P_W-1:0] smul(input logic signed [A_W-1:0] d,
                                                   input logic signed [B_W-1:0] t);
        return P_W'(d) * P_W'(t);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
            s2_tag   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_rr    <= smul(s1_ar, s1_wr);
            s2_ii    <= smul(s1_ai, s1_wi);
            s2_ri    <= smul(s1_ar, s1_wi);
            s2_ir    <= smul(s1_ai, s1_wr);
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- S3: combine, scale, register ----------------
    logic signed [S_W-1:0]   re_full, im_full;
    logic signed [OUT_W-1:0] re_scaled, im_scaled;
    logic                    re_ovf, im_ovf;

    assign re_full = S_W'(s2_rr) - S_W'(s2_ii);
    assign im_full = S_W'(s2_ri) + S_W'(s2_ir);

    fft_scale #(.IN_W(S_W), .FRAC(FRAC_BITS), .OUT_W(OUT_W)) u_scale_re (
        .x   (re_full),
        .y   (re_scaled),
        .ovf (re_ovf)
    );

    fft_scale #(.IN_W(S_W), .FRAC(FRAC_BITS), .OUT_W(OUT_W)) u_scale_im (
        .x   (im_full),
        .y   (im_scaled),
        .ovf (im_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            y_re      <= re_scaled;
            y_im      <= im_scaled;
            out_tag   <= s2_tag;
            ovf       <= re_ovf | im_ovf;
        end
    end

endmodule

// File: tb/tb_cmplx_twiddle_mult.sv
`timescale 1ns/1ps
module tb_cmplx_twiddle_mult;
    import fft_pkg::*;

    localparam int A_W   = 8;
    localparam int B_W   = 9;
    localparam int OUT_W = 9;
    localparam int TAG_W = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_W-1:0]   a_re, a_im;
    logic signed [B_W-1:0]   w_re, w_im;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] y_re, y_im;
    logic [TAG_W-1:0]        out_tag;
    logic                    ovf;

    always #5 clk = ~clk;

    cmplx_twiddle_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .out_tag   (out_tag),
        .ovf       (ovf)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         re;
        int         im;
        int         ov;
        logic [3:0] tag;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] out_tags[$];
    int         out_cnt = 0;

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Scale a mathematically exact component to the output format.
    function automatic void scale(input int v, output int y, output int o);
        int q;
        int hi;
        int lo;
        hi = 2 ** (OUT_W - 1) - 1;
        lo = -(2 ** (OUT_W - 1));
        o  = 0;
`ifdef ROUND_SAT_EN
        q = floor_div(v + TW_ONE / 2, TW_ONE);
        if (q > hi) begin q = hi; o = 1; end
        else if (q < lo) begin q = lo; o = 1; end
`else
        q = floor_div(v, TW_ONE) % (2 ** OUT_W);
        if (q < 0) q = q + 2 ** OUT_W;
        if (q > hi) q = q - 2 ** OUT_W;
`endif
        y = q;
    endfunction

    function automatic beat_t model(input int ar, input int ai, input int wr, input int wi,
                                    input logic [3:0] tag);
        beat_t b;
        int    o_re;
        int    o_im;
        scale(ar * wr - ai * wi, b.re, o_re);
        scale(ar * wi + ai * wr, b.im, o_im);
        b.ov  = o_re | o_im;
        b.tag = tag;
        return b;
    endfunction

    // Scoreboard bookkeeping on each edge (sees pre-edge values).
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (out_valid && out_ready) begin
                out_cnt++;
                out_tags.push_back(out_tag);
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(int'(a_re), int'(a_im), int'(w_re), int'(w_im), in_tag));
        end
    end

    // Compare process: every cycle a result is presented (also while stalled).
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                check("sb_y_re", longint'(y_re), longint'(exp_q[0].re));
                check("sb_y_im", longint'(y_im), longint'(exp_q[0].im));
                check("sb_tag", longint'(out_tag), longint'(exp_q[0].tag));
                check("sb_ovf", longint'(ovf), longint'(exp_q[0].ov));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int ar, input int ai, input int wr, input int wi, input int tag);
        a_re   = A_W'(ar);
        a_im   = A_W'(ai);
        w_re   = B_W'(wr);
        w_im   = B_W'(wi);
        in_tag = TAG_W'(tag);
    endtask

    // One beat into an empty pipeline; checks latency and literal results.
    // Called at posedge+1.
    task automatic single(input string name, input int ar, input int ai, input int wr,
                          input int wi, input int tag, input int e_re, input int e_im,
                          input int e_ovf);
        set_in(ar, ai, wr, wi, tag);
        in_valid = 1'b1;
        check({name, "_in_ready"}, longint'(in_ready), 1);
        @(posedge clk); #1;                      // accepting edge
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_not_yet_valid"}, longint'(out_valid), 0);
        @(posedge clk); #1;                      // third edge
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_re"}, longint'(y_re), e_re);
        check({name, "_im"}, longint'(y_im), e_im);
        check({name, "_ovf"}, longint'(ovf), e_ovf);
        check({name, "_tag"}, longint'(out_tag), tag);
        @(posedge clk); #1;
        check({name, "_drained"}, longint'(out_valid), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        beat_t m;
        int    c;
        int    sent;
        bit    saw_stall;
        bit    acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y_re", longint'(y_re), 0);
        check("rst_y_im", longint'(y_im), 0);
        check("rst_out_tag", longint'(out_tag), 0);
        check("rst_ovf", longint'(ovf), 0);

        // Pin the model against hand-computed values.
        m = model(100, -50, 128, 0, 4'h1);
        check("model_identity_re", m.re, 100);
        check("model_identity_im", m.im, -50);
        m = model(127, 127, 255, 255, 4'h0);
`ifdef ROUND_SAT_EN
        check("model_ovf_im", m.im, 255);
        check("model_ovf_flag", m.ov, 1);
`else
        check("model_ovf_im", m.im, -6);
        check("model_ovf_flag", m.ov, 0);
`endif

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        single("identity", 100, -50, 128, 0, 3, 100, -50, 0);
        single("minus_j", 100, -50, 0, -128, 4'hA, -50, -100, 0);
`ifdef ROUND_SAT_EN
        single("scale_pos", 1, 0, 64, 0, 1, 1, 0, 0);
        single("scale_neg", -1, 0, 64, 0, 2, 0, 0, 0);
        single("overflow", 127, 127, 255, 255, 5, 0, 255, 1);
`else
        single("scale_pos", 1, 0, 64, 0, 1, 0, 0, 0);
        single("scale_neg", -1, 0, 64, 0, 2, -1, 0, 0);
        single("overflow", 127, 127, 255, 255, 5, 0, -6, 0);
`endif

        // Back-pressure: 6 beats, out_ready low for 5 cycles mid-stream.
        out_cnt = 0;
        out_tags.delete();
        c         = 0;
        sent      = 0;
        saw_stall = 1'b0;
        while (sent < 6 && c < 100) begin
            out_ready = !(c >= 3 && c < 8);
            set_in(10 * sent + 3, -7 * sent, 90 - 20 * sent, 30 * sent - 60, sent);
            in_valid = 1'b1;
            #2;
            acc = in_ready;
            if (!in_ready) saw_stall = 1'b1;
            @(posedge clk); #1;
            if (acc) sent++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_sent", sent, 6);
        check("bp_in_ready_dropped", longint'(saw_stall), 1);
        for (int i = 0; i < 30 && out_cnt < 6; i++) @(posedge clk);
        #1;
        check("bp_out_count", out_cnt, 6);
        check("bp_tag_count", out_tags.size(), 6);
        for (int i = 0; i < 6 && i < out_tags.size(); i++)
            check("bp_tag_order", longint'(out_tags[i]), i);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            set_in(20 + i, 5, 100, 10, 7 + i);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", longint'(out_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_y_re", longint'(y_re), 0);
        check("mid_rst_tag", longint'(out_tag), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_stale", longint'(out_valid), 0);
        end
        single("after_rst", 64, 32, 64, -64, 4'hC, 48, -16, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
